// File: rtl/r4mbe_iterative_multiplier_if.sv
// rtl/r4mbe_iterative_multiplier_if.sv - request/response handshake bundle for the iterative Booth multiplier
interface r4mbe_iterative_multiplier_if #(
  parameter int DATAW = 8
);
  logic                 i_valid;
  logic                 o_ready;
  logic [DATAW-1:0]     i_A;
  logic [DATAW-1:0]     i_B;
  logic                 i_signed;
  logic                 o_valid;
  logic                 i_ready;
  logic [2*DATAW-1:0]   o_result;

  // Requester/consumer side
  modport master (
    output i_valid, i_A, i_B, i_signed, i_ready,
    input  o_ready, o_valid, o_result
  );

  // Multiplier side
  modport slave (
    input  i_valid, i_A, i_B, i_signed, i_ready,
    output o_ready, o_valid, o_result
  );
endinterface

// File: rtl/r4mbe_iterative_multiplier.sv
// rtl/r4mbe_iterative_multiplier.sv - sequential radix-4 modified-Booth multiplier, one digit per clock
module r4mbe_iterative_multiplier #(
  parameter int DATAW = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  r4mbe_iterative_multiplier_if.slave bus
);
  localparam int NDIG = DATAW / 2 + 1;
  localparam int AW   = 2 * DATAW + 2;
  localparam int BW   = DATAW + 3;
  localparam int CW   = $clog2(NDIG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        a_q, a_d;
  logic [BW-1:0]        b_q, b_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [2*DATAW-1:0]   result_q, result_d;

  logic                 ready;
  logic                 accept;
  logic                 last_digit;
  logic                 a_sign;
  logic                 b_sign;
  logic [AW-1:0]        a_ext;
  logic [BW-1:0]        b_ext;
  logic [2:0]           win;
  logic                 pp_zero;
  logic                 pp_two;
  logic                 pp_neg;
  logic [AW-1:0]        mag;
  logic [AW-1:0]        mag_sh;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        sum;

  // Upstream may hand over a new request while idle, or while the finished
  // result is being taken so that DONE and the next accept share a cycle.
  assign ready        = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.i_ready);
  assign accept       = bus.i_valid && ready;
  assign bus.o_ready  = ready;
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;

  // Operand extension: A widened to the accumulator, B gets two guard bits
  // and the implicit zero below bit 0 so every digit window is 3 bits wide.
  assign a_sign = bus.i_signed & bus.i_A[DATAW-1];
  assign b_sign = bus.i_signed & bus.i_B[DATAW-1];
  assign a_ext  = {{(AW-DATAW){a_sign}}, bus.i_A};
  assign b_ext  = {{2{b_sign}}, bus.i_B, 1'b0};

  assign last_digit = (cnt_q == CW'(NDIG - 1));

  // Select the current Booth window and the matching 2i shift of the partial product.
  always_comb begin
    win    = '0;
    mag_sh = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_q == CW'(i)) begin
        win    = b_q[2*i +: 3];
        mag_sh = mag << (2 * i);
      end
    end
  end

  // Radix-4 Booth recoding of the window into zero / x1 / x2 and a sign.
  always_comb begin
    pp_zero = 1'b0;
    pp_two  = 1'b0;
    pp_neg  = 1'b0;
    case (win)
      3'b000, 3'b111: pp_zero = 1'b1;
      3'b001, 3'b010: pp_neg  = 1'b0;
      3'b011:         pp_two  = 1'b1;
      3'b100: begin
        pp_two = 1'b1;
        pp_neg = 1'b1;
      end
      default:        pp_neg  = 1'b1;
    endcase
  end

  // Negation is one's complement plus a carry-in folded into the same add.
  assign mag    = pp_zero ? '0 : (pp_two ? (a_q << 1) : a_q);
  assign addend = pp_neg ? ~mag_sh : mag_sh;
  assign sum    = acc_q + addend + AW'(pp_neg);

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = a_ext;
          b_d     = b_ext;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
        if (last_digit) begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          result_d = sum[2*DATAW-1:0];
        end
      end
      S_DONE: begin
        if (bus.i_ready) begin
          valid_d = 1'b0;
          if (accept) begin
            a_d     = a_ext;
            b_d     = b_ext;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register with reset overriding everything in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_r4mbe_iterative_multiplier.sv
// tb/tb_r4mbe_iterative_multiplier.sv - self-checking bench for the iterative Booth multiplier
module tb_r4mbe_iterative_multiplier;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  r4mbe_iterative_multiplier_if #(.DATAW(8))  b8 ();
  r4mbe_iterative_multiplier_if #(.DATAW(16)) b16 ();

  r4mbe_iterative_multiplier #(.DATAW(8)) dut8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b8)
  );

  r4mbe_iterative_multiplier #(.DATAW(16)) dut16 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b16)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  logic        so_valid;
  logic        so_ready;
  logic [31:0] so_result;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Golden product from plain integer arithmetic on the w-bit operands.
  function automatic logic [31:0] gold(input int w, input logic [15:0] a, input logic [15:0] b,
                                       input logic s);
    longint m, sa, sb, p;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (s && sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
    if (s && sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic int nd(input bit sel);
    return sel ? 9 : 5;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic r);
    if (sel) begin
      b16.i_valid = v; b16.i_A = a; b16.i_B = b; b16.i_signed = s; b16.i_ready = r;
    end else begin
      b8.i_valid = v; b8.i_A = a[7:0]; b8.i_B = b[7:0]; b8.i_signed = s; b8.i_ready = r;
    end
  endtask

  task automatic sample(input bit sel);
    if (sel) begin
      so_valid = b16.o_valid; so_ready = b16.o_ready; so_result = b16.o_result;
    end else begin
      so_valid = b8.o_valid; so_ready = b8.o_ready; so_result = {16'h0, b8.o_result};
    end
  endtask

  task automatic tick(input bit sel);
    @(posedge clk);
    #1;
    sample(sel);
  endtask

  task automatic settle(input bit sel);
    #1;
    sample(sel);
  endtask

  // Called just after the accept edge: busy for NDIG cycles, then the product.
  task automatic wait_result(input bit sel, input string tag, input logic [31:0] exp);
    for (int i = 0; i < nd(sel); i++) begin
      chk({tag, "_busy_valid"}, so_valid, 1'b0);
      chk({tag, "_busy_ready"}, so_ready, 1'b0);
      tick(sel);
    end
    chk({tag, "_valid"}, so_valid, 1'b1);
    chk({tag, "_result"}, so_result, exp);
  endtask

  task automatic do_op(input bit sel, input logic [15:0] a, input logic [15:0] b, input logic s,
                       input string tag, input logic [31:0] exp);
    drive(sel, 1'b1, a, b, s, 1'b0);
    settle(sel);
    chk({tag, "_accept_ready"}, so_ready, 1'b1);
    tick(sel);
    drive(sel, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    wait_result(sel, tag, exp);
  endtask

  task automatic retire(input bit sel, input string tag);
    drive(sel, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick(sel);
    drive(sel, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk({tag, "_retire_valid"}, so_valid, 1'b0);
    settle(sel);
    chk({tag, "_retire_ready"}, so_ready, 1'b1);
  endtask

  // Cycle loop with a queue scoreboard; requester holds i_valid until accepted.
  task automatic stream(input bit sel, input int nops, input bit stalls, input string tag);
    logic [31:0] q[$];
    logic [31:0] exp;
    logic [31:0] held;
    logic [15:0] a, b;
    logic        s, v, r, stalled;
    int          sent, got, cyc, last_out, limit, w;
    sent = 0; got = 0; cyc = 0; last_out = -1;
    limit = nops * 40 + 100;
    w = sel ? 16 : 8;
    v = 1'b0; a = '0; b = '0; s = 1'b0; stalled = 1'b0; held = '0;
    while (got < nops && cyc < limit) begin
      if (stalled) begin
        chk({tag, "_hold_valid"}, so_valid, 1'b1);
        chk({tag, "_hold_result"}, so_result, held);
      end
      if (!v && sent < nops && (!stalls || $urandom_range(0, 3) != 0)) begin
        v = 1'b1;
        a = 16'($urandom);
        b = 16'($urandom);
        s = 1'($urandom);
      end
      r = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive(sel, v, a, b, s, r);
      settle(sel);
      if (so_valid && r) begin
        chk({tag, "_pending"}, 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp = q.pop_front();
          chk({tag, "_result"}, so_result, exp);
        end
        if (!stalls && last_out >= 0) chk({tag, "_spacing"}, cyc - last_out, nd(sel) + 1);
        last_out = cyc;
        got++;
      end
      stalled = so_valid && !r;
      held = so_result;
      if (v && so_ready) begin
        q.push_back(gold(w, a, b, s));
        sent++;
        v = 1'b0;
      end
      tick(sel);
      cyc++;
    end
    chk({tag, "_count"}, got, nops);
    drive(sel, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick(sel);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick(1'b0);
    tick(1'b0);
    chk("rst_valid", so_valid, 1'b0);
    chk("rst_result", so_result, 32'h0);
    chk("rst_ready", so_ready, 1'b1);
    sample(1'b1);
    chk("rst16_valid", so_valid, 1'b0);
    chk("rst16_result", so_result, 32'h0);
    rst = 1'b0;
    tick(1'b0);

    do_op(1'b0, 16'hFF, 16'hFF, 1'b0, "umax", 32'hFE01);
    retire(1'b0, "umax");
    do_op(1'b0, 16'h80, 16'h80, 1'b1, "s_m128_m128", 32'h4000);
    retire(1'b0, "s_m128_m128");
    do_op(1'b0, 16'h80, 16'h7F, 1'b1, "s_m128_127", 32'hC080);
    retire(1'b0, "s_m128_127");
    do_op(1'b0, 16'hFF, 16'h01, 1'b1, "s_m1_1", 32'hFFFF);
    retire(1'b0, "s_m1_1");
    do_op(1'b0, 16'h00, 16'hB3, 1'b1, "s_0_m77", 32'h0000);
    retire(1'b0, "s_0_m77");

    // Backpressure: result held while a new request waits, then same-edge accept.
    do_op(1'b0, 16'h5A, 16'hC3, 1'b0, "bp_first", 32'h448E);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 16'h11 + 16'(i), 16'h22, 1'b0, 1'b0);
      settle(1'b0);
      chk("bp_stall_ready", so_ready, 1'b0);
      tick(1'b0);
      chk("bp_stall_valid", so_valid, 1'b1);
      chk("bp_stall_result", so_result, 32'h448E);
    end
    drive(1'b0, 1'b1, 16'h0D, 16'h0B, 1'b1, 1'b1);
    settle(1'b0);
    chk("bp_release_ready", so_ready, 1'b1);
    tick(1'b0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    wait_result(1'b0, "bp_second", 32'h008F);
    retire(1'b0, "bp_second");

    // Reset on RUN cycle 2 discards the operation.
    drive(1'b0, 1'b1, 16'h37, 16'h59, 1'b0, 1'b0);
    tick(1'b0);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick(1'b0);
    rst = 1'b1;
    tick(1'b0);
    chk("rrun_valid", so_valid, 1'b0);
    chk("rrun_result", so_result, 32'h0);
    chk("rrun_ready", so_ready, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0);
      chk("rrun_no_valid", so_valid, 1'b0);
    end

    // Reset while DONE clears the pending result.
    do_op(1'b0, 16'hC8, 16'h0F, 1'b0, "rdone", 32'h0BB8);
    rst = 1'b1;
    tick(1'b0);
    chk("rdone_valid", so_valid, 1'b0);
    chk("rdone_result", so_result, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0);
      chk("rdone_no_valid", so_valid, 1'b0);
    end

    do_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, "w16_umax", 32'hFFFE0001);
    retire(1'b1, "w16_umax");
    do_op(1'b1, 16'h8000, 16'h8000, 1'b1, "w16_smin", 32'h40000000);
    retire(1'b1, "w16_smin");

    stream(1'b0, 20, 1'b0, "b2b");
    stream(1'b0, 2500, 1'b1, "rnd8");
    stream(1'b1, 1500, 1'b1, "rnd16");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
